pll_phase_ctrl: RTL and testbench

//  Drives the ECP5 EHXPLLL dynamic phase-adjust inputs: PHASESEL, PHASEDIR, PHASESTEP and PHASELOADREG.

---
 rtl/pll_ctrl_pkg.sv | 40 ++++
 rtl/pll_lock_filter.sv | 38 +++
 rtl/pll_phase_ctrl.sv | 151 +++++++++++++++
 tb/tb_pll_phase_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_ctrl_pkg.sv
// Shared types and constants for the EHXPLLL dynamic phase-adjust controller.
`timescale 1ns/1ps
package pll_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    PULSE = 3'd2,
    GAP   = 3'd3,
    LOAD  = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [1:0] PHASESEL_CLKOS  = 2'b00;
  localparam logic [1:0] PHASESEL_CLKOS2 = 2'b01;
  localparam logic [1:0] PHASESEL_CLKOS3 = 2'b10;
  localparam logic [1:0] PHASESEL_CLKOP  = 2'b11;

  localparam logic PHASESTEP_IDLE    = 1'b1;
  localparam logic PHASELOADREG_IDLE = 1'b1;

  // One CLKOS step in either direction, wrapping within 0..modulus-1.
  function automatic logic [6:0] step_pos(input logic [6:0] pos, input logic dir,
                                          input int modulus);
    logic [6:0] res;
    if (dir) begin
      res = (int'(pos) == modulus - 1) ? 7'd0 : pos + 7'd1;
    end else begin
      res = (pos == 7'd0) ? 7'(modulus - 1) : pos - 7'd1;
    end
    return res;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pll_lock_filter.sv
// Synchronises the asynchronous PLL LOCK and turns it into a debounced system reset.
`timescale 1ns/1ps
module pll_lock_filter #(
  parameter int LOCK_FILT = 1024
) (
  input  logic clk,
  input  logic resetn,
  input  logic pll_locked,
  output logic sys_resetn
);

  localparam int CNT_W = $clog2(LOCK_FILT + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(LOCK_FILT);

  logic             sync1;
  logic             lk;
  logic [CNT_W-1:0] cnt;

  // Any single low sample of lk restarts the full qualification window.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync1      <= 1'b0;
      lk         <= 1'b0;
      cnt        <= '0;
      sys_resetn <= 1'b0;
    end else begin
      sync1 <= pll_locked;
      lk    <= sync1;
      if (!lk) begin
        cnt <= '0;
      end else if (cnt != CNT_FULL) begin
        cnt <= cnt + 1'b1;
      end
      sys_resetn <= lk && (cnt == CNT_FULL);
    end
  end

endmodule

// File: rtl/pll_phase_ctrl.sv
// Sequences PHASESEL/PHASEDIR/PHASESTEP/PHASELOADREG for the ECP5 EHXPLLL and tracks CLKOS phase.
`timescale 1ns/1ps
module pll_phase_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int STEP_W    = 8,
  parameter int SETUP_CYC = 4,
  parameter int PULSE_CYC = 4,
  parameter int GAP_CYC   = 8,
  parameter int PHASE_MOD = 104,
  parameter int LOCK_FILT = 1024
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              pll_locked,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_sel,
  input  logic              cmd_dir,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic              cmd_load,
  output logic [1:0]        phasesel,
  output logic              phasedir,
  output logic              phasestep,
  output logic              phaseloadreg,
  output logic              busy,
  output logic              err_unlock,
  output logic [6:0]        phase_pos,
  output logic              sys_resetn,
  output state_t            dbg_state
);

  localparam int DUR_W = $clog2(max3(SETUP_CYC, PULSE_CYC, GAP_CYC) + 1);
  localparam logic [DUR_W-1:0] DUR_SETUP = DUR_W'(SETUP_CYC);
  localparam logic [DUR_W-1:0] DUR_PULSE = DUR_W'(PULSE_CYC - 1);
  localparam logic [DUR_W-1:0] DUR_GAP   = DUR_W'(GAP_CYC - 1);

  state_t            state;
  logic [DUR_W-1:0]  dur;
  logic [STEP_W-1:0] remaining;
  logic              load_q;

  pll_lock_filter #(
    .LOCK_FILT (LOCK_FILT)
  ) u_lock_filter (
    .clk        (clk),
    .resetn     (resetn),
    .pll_locked (pll_locked),
    .sys_resetn (sys_resetn)
  );

  // Handshake: a command transfers on a rising clk edge where cmd_valid and cmd_ready
  // are both high; cmd_ready depends only on registered state, never on cmd_valid.
  assign cmd_ready = (state == IDLE) && sys_resetn;
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= IDLE;
      dur          <= '0;
      remaining    <= '0;
      load_q       <= 1'b0;
      phasesel     <= PHASESEL_CLKOS;
      phasedir     <= 1'b1;
      phasestep    <= PHASESTEP_IDLE;
      phaseloadreg <= PHASELOADREG_IDLE;
      err_unlock   <= 1'b0;
      phase_pos    <= '0;
    end else if (state != IDLE && !sys_resetn) begin
      // Lock lost: release the PLL strobes and abandon the command; an unfinished
      // pulse never reaches PULSE exit so phase_pos is left untouched.
      state        <= IDLE;
      phasestep    <= PHASESTEP_IDLE;
      phaseloadreg <= PHASELOADREG_IDLE;
      err_unlock   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            phasesel  <= cmd_sel;
            phasedir  <= cmd_dir;
            remaining <= cmd_steps;
            load_q    <= cmd_load;
            dur       <= DUR_SETUP;
            state     <= SETUP;
          end
        end
        SETUP: begin
          // Counting from SETUP_CYC down to 0 puts the first step SETUP_CYC+1 cycles after accept.
          if (dur != '0) begin
            dur <= dur - 1'b1;
          end else if (remaining != '0) begin
            phasestep <= 1'b0;
            dur       <= DUR_PULSE;
            state     <= PULSE;
          end else if (load_q) begin
            phaseloadreg <= 1'b0;
            dur          <= DUR_PULSE;
            state        <= LOAD;
          end else begin
            state <= DONE;
          end
        end
        PULSE: begin
          if (dur != '0) begin
            dur <= dur - 1'b1;
          end else begin
            phasestep <= PHASESTEP_IDLE;
            remaining <= remaining - 1'b1;
            if (phasesel == PHASESEL_CLKOS) begin
              phase_pos <= step_pos(phase_pos, phasedir, PHASE_MOD);
            end
            dur   <= DUR_GAP;
            state <= GAP;
          end
        end
        GAP: begin
          if (dur != '0) begin
            dur <= dur - 1'b1;
          end else if (remaining != '0) begin
            phasestep <= 1'b0;
            dur       <= DUR_PULSE;
            state     <= PULSE;
          end else if (load_q) begin
            phaseloadreg <= 1'b0;
            dur          <= DUR_PULSE;
            state        <= LOAD;
          end else begin
            state <= DONE;
          end
        end
        LOAD: begin
          if (dur != '0) begin
            dur <= dur - 1'b1;
          end else begin
            phaseloadreg <= PHASELOADREG_IDLE;
            state        <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Directed bench for pll_phase_ctrl: command table plus lock, unlock, chaining and reset sequences.
`timescale 1ns/1ps
module tb_pll_phase_ctrl;
  import pll_ctrl_pkg::*;

  localparam int STEP_W = 8;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              pll_locked = 1'b0;
  logic              cmd_valid = 1'b0;
  logic [1:0]        cmd_sel = 2'b00;
  logic              cmd_dir = 1'b0;
  logic [STEP_W-1:0] cmd_steps = '0;
  logic              cmd_load = 1'b0;
  logic              cmd_ready;
  logic [1:0]        phasesel;
  logic              phasedir;
  logic              phasestep;
  logic              phaseloadreg;
  logic              busy;
  logic              err_unlock;
  logic [6:0]        phase_pos;
  logic              sys_resetn;
  state_t            dbg_state;

  pll_phase_ctrl #(
    .STEP_W (STEP_W)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .pll_locked   (pll_locked),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_sel      (cmd_sel),
    .cmd_dir      (cmd_dir),
    .cmd_steps    (cmd_steps),
    .cmd_load     (cmd_load),
    .phasesel     (phasesel),
    .phasedir     (phasedir),
    .phasestep    (phasestep),
    .phaseloadreg (phaseloadreg),
    .busy         (busy),
    .err_unlock   (err_unlock),
    .phase_pos    (phase_pos),
    .sys_resetn   (sys_resetn),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock ----------------
  always #20 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] exp_q[$];

  typedef struct {
    logic [1:0] sel;
    logic       dir;
    int         steps;
    logic       load;
    int         exp_pos;
    int         exp_first_pos;
    int         exp_busy;
    int         exp_load_at;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check($sformatf("%s_ready", tag), cmd_ready, 0);
    check($sformatf("%s_phasesel", tag), phasesel, 0);
    check($sformatf("%s_phasedir", tag), phasedir, 1);
    check($sformatf("%s_phasestep", tag), phasestep, 1);
    check($sformatf("%s_phaseloadreg", tag), phaseloadreg, 1);
    check($sformatf("%s_busy", tag), busy, 0);
    check($sformatf("%s_err_unlock", tag), err_unlock, 0);
    check($sformatf("%s_phase_pos", tag), phase_pos, 0);
    check($sformatf("%s_sys_resetn", tag), sys_resetn, 0);
    check($sformatf("%s_state", tag), dbg_state, IDLE);
  endtask

  // ---------------- driver tasks ----------------
  // Called at a negedge; leaves the bench at the negedge after edge accept+t.
  task automatic accept_cmd(input logic [1:0] sel, input logic dir, input int steps,
                            input logic load);
    cmd_valid = 1'b1;
    cmd_sel   = sel;
    cmd_dir   = dir;
    cmd_steps = STEP_W'(steps);
    cmd_load  = load;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_sel   = ~sel;
    cmd_dir   = ~dir;
    cmd_steps = 8'hA5;
    cmd_load  = ~load;
  endtask

  task automatic wait_lock(input string tag);
    int k;
    pll_locked = 1'b1;
    for (k = 1; k <= 1200; k++) begin
      @(negedge clk);
      if (sys_resetn) break;
    end
    check($sformatf("%s_lock_latency", tag), k, 1027);
    check($sformatf("%s_ready_after_lock", tag), cmd_ready, 1);
  endtask

  task automatic run_cmd(input vec_t v, input string tag);
    int   t;
    int   low_run = 0;
    int   width_err = 0;
    int   load_low = 0;
    int   load_first = -1;
    int   busy_len = -1;
    int   first_pos;
    logic prev_step = 1'b1;
    first_pos = int'(phase_pos);
    for (int k = 0; k < v.steps; k++) exp_q.push_back(16'(5 + 12 * k));
    check($sformatf("%s_ready", tag), cmd_ready, 1);
    accept_cmd(v.sel, v.dir, v.steps, v.load);
    for (t = 0; t < 5000; t++) begin
      @(negedge clk);
      if (phasestep == 1'b0) begin
        if (prev_step) begin
          if (exp_q.size() == 0) check($sformatf("%s_extra_pulse", tag), t, 32'hFFFF_FFFF);
          else check($sformatf("%s_pulse_fall", tag), t, exp_q.pop_front());
        end
        low_run++;
      end else if (!prev_step) begin
        if (low_run != 4) width_err++;
        low_run = 0;
      end
      prev_step = phasestep;
      if (phaseloadreg == 1'b0) begin
        if (load_low == 0) load_first = t;
        load_low++;
      end
      if (t == 9) first_pos = int'(phase_pos);
      if (!busy) begin
        busy_len = t;
        break;
      end
    end
    check($sformatf("%s_busy_len", tag), busy_len, v.exp_busy);
    check($sformatf("%s_missing_pulses", tag), exp_q.size(), 0);
    exp_q.delete();
    check($sformatf("%s_pulse_width", tag), width_err, 0);
    check($sformatf("%s_load_cycles", tag), load_low, v.load ? 4 : 0);
    if (v.load) check($sformatf("%s_load_at", tag), load_first, v.exp_load_at);
    check($sformatf("%s_first_pos", tag), first_pos, v.exp_first_pos);
    check($sformatf("%s_phase_pos", tag), phase_pos, v.exp_pos);
    check($sformatf("%s_phasesel", tag), phasesel, v.sel);
    check($sformatf("%s_phasedir", tag), phasedir, v.dir);
    check($sformatf("%s_phasestep_idle", tag), phasestep, 1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    //                sel    dir   steps load  pos  first busy load_at
    vecs[0] = '{2'd0, 1'b0, 2, 1'b0, 102, 103, 30, -1};
    vecs[1] = '{2'd3, 1'b1, 5, 1'b0, 102, 102, 66, -1};
    vecs[2] = '{2'd0, 1'b1, 3, 1'b0,   1, 103, 42, -1};
    vecs[3] = '{2'd0, 1'b0, 0, 1'b1,   1,   1, 10,  5};
    vecs[4] = '{2'd1, 1'b1, 1, 1'b1,   1,   1, 22, 17};
    vecs[5] = '{2'd2, 1'b0, 0, 1'b0,   1,   1,  6, -1};
    vecs[6] = '{2'd0, 1'b1, 2, 1'b1,   3,   2, 34, 29};

    // Reset values, then lock qualification.
    repeat (3) @(negedge clk);
    check_reset("reset");
    resetn = 1'b1;
    repeat (8) @(negedge clk);
    check("prelock_sys_resetn", sys_resetn, 0);
    check("prelock_ready", cmd_ready, 0);
    wait_lock("lock");

    for (int i = 0; i < 7; i++) begin
      run_cmd(vecs[i], $sformatf("vec%0d", i));
      @(negedge clk);
    end

    // Holding cmd_valid chains commands with one IDLE cycle between them.
    cmd_valid = 1'b1;
    cmd_sel   = 2'd2;
    cmd_dir   = 1'b0;
    cmd_steps = '0;
    cmd_load  = 1'b0;
    @(posedge clk);
    repeat (7) @(negedge clk);
    check("chain_gap_busy", busy, 0);
    check("chain_gap_ready", cmd_ready, 1);
    @(negedge clk);
    check("chain_second_busy", busy, 1);
    cmd_valid = 1'b0;
    for (int k = 0; k < 20 && busy; k++) @(negedge clk);
    check("chain_end_busy", busy, 0);
    check("chain_pos", phase_pos, 3);

    // Lock drop while the 2nd of 4 pulses is low.
    begin
      int t;
      accept_cmd(2'd0, 1'b1, 4, 1'b0);
      for (t = 0; t <= 21; t++) begin
        @(negedge clk);
        if (t == 17) pll_locked = 1'b0;
        if (t == 20) begin
          check("unlock_pulse_low", phasestep, 0);
          check("unlock_sys_resetn", sys_resetn, 0);
          check("unlock_err_before", err_unlock, 0);
          check("unlock_busy_before", busy, 1);
        end
      end
      check("unlock_phasestep", phasestep, 1);
      check("unlock_phaseloadreg", phaseloadreg, 1);
      check("unlock_err", err_unlock, 1);
      check("unlock_busy", busy, 0);
      check("unlock_ready", cmd_ready, 0);
      check("unlock_phase_pos", phase_pos, 4);
    end
    cmd_valid = 1'b1;
    cmd_steps = 8'd1;
    repeat (3) @(negedge clk);
    check("unlocked_no_accept", busy, 0);
    cmd_valid = 1'b0;
    wait_lock("relock");
    check("relock_err_sticky", err_unlock, 1);

    // Synchronous reset while a step pulse is low.
    accept_cmd(2'd0, 1'b1, 3, 1'b0);
    repeat (7) @(negedge clk);
    check("rst_pulse_low", phasestep, 0);
    resetn = 1'b0;
    @(negedge clk);
    check_reset("midrst");
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
